// File: rtl/toy_fetch_mem_rsp.sv
// rtl/toy_fetch_mem_rsp.sv - instruction fetch responder: request accept, ITCM read, in-order ack FIFO
//
// Accepts fetch requests, issues one single-cycle-latency SRAM read per request and
// returns the fetched line, tagged with the request entry_id, in accept order.
//
// Optional feature macro: FETCH_RSP_ADDR_CHK_EN
//   Requests outside [ITCM_BASE, ITCM_BASE+ITCM_SIZE) do not read the SRAM.
//   They ack with data=0 and fetch_mem_ack_err=1.
//   fetch_mem_ack_err exists only when the macro is defined.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   fetch_mem_req_*          request channel (vld/rdy, byte addr, entry_id)
//   fetch_mem_ack_*          ack channel (vld/rdy, data, entry_id, err)
//   inst_mem_en/addr         SRAM read strobe and line-aligned byte address
//   inst_mem_rd_data         SRAM read data, valid the cycle after inst_mem_en

module toy_fetch_mem_rsp #(
    parameter int                  ADDR_WIDTH         = 32,
    parameter int                  FETCH_DATA_WIDTH   = 128,
    parameter int                  ROB_ENTRY_ID_WIDTH = 4,
    parameter int                  RSP_FIFO_DEPTH     = 4,
    parameter logic [ADDR_WIDTH:0] ITCM_BASE          = '0,
    parameter logic [ADDR_WIDTH:0] ITCM_SIZE          = (ADDR_WIDTH+1)'(32'h0001_0000)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_mem_req_vld,
    output logic                          fetch_mem_req_rdy,
    input  logic [ADDR_WIDTH-1:0]         fetch_mem_req_addr,
    input  logic [ROB_ENTRY_ID_WIDTH-1:0] fetch_mem_req_entry_id,
    output logic                          fetch_mem_ack_vld,
    input  logic                          fetch_mem_ack_rdy,
    output logic [FETCH_DATA_WIDTH-1:0]   fetch_mem_ack_data,
    output logic [ROB_ENTRY_ID_WIDTH-1:0] fetch_mem_ack_entry_id,
`ifdef FETCH_RSP_ADDR_CHK_EN
    output logic                          fetch_mem_ack_err,
`endif
    output logic                          inst_mem_en,
    output logic [ADDR_WIDTH-1:0]         inst_mem_addr,
    input  logic [FETCH_DATA_WIDTH-1:0]   inst_mem_rd_data
);

    localparam int OFS_W = $clog2(FETCH_DATA_WIDTH / 8);
    localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

    localparam logic [ADDR_WIDTH:0] WIN_LO = ITCM_BASE;
    localparam logic [ADDR_WIDTH:0] WIN_HI = ITCM_BASE + ITCM_SIZE;

    // S1 stage: one request whose SRAM data returns this cycle
    logic                          s1_vld;
    logic [ROB_ENTRY_ID_WIDTH-1:0] s1_id;
    logic                          s1_err;

    // ack FIFO
    logic [FETCH_DATA_WIDTH-1:0]   fifo_data [RSP_FIFO_DEPTH];
    logic [ROB_ENTRY_ID_WIDTH-1:0] fifo_id   [RSP_FIFO_DEPTH];
    logic [RSP_FIFO_DEPTH-1:0]     fifo_err;
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [CNT_W-1:0]              count;

    logic                          accept;
    logic                          in_win;
    logic                          req_err;
    logic                          push;
    logic                          pop;
    logic [FETCH_DATA_WIDTH-1:0]   push_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A FIFO slot is reserved for the request sitting in S1, so the S1 push can
    // never overflow. Only registered state feeds ready; ack_rdy has no path here.
    assign fetch_mem_req_rdy = ({1'b0, count} + (CNT_W+1)'(s1_vld))
                               < (CNT_W+1)'(RSP_FIFO_DEPTH);
    assign accept = fetch_mem_req_vld && fetch_mem_req_rdy;

    assign in_win = ({1'b0, fetch_mem_req_addr} >= WIN_LO) &&
                    ({1'b0, fetch_mem_req_addr} <  WIN_HI);

`ifdef FETCH_RSP_ADDR_CHK_EN
    assign req_err = !in_win;
`else
    logic unused_win;
    assign unused_win = in_win;
    assign req_err    = 1'b0;
`endif

    assign inst_mem_en   = accept && !req_err;
    assign inst_mem_addr = {fetch_mem_req_addr[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_id  <= '0;
            s1_err <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_id  <= fetch_mem_req_entry_id;
                s1_err <= req_err;
            end
        end
    end

    // Out-of-window requests never strobed the SRAM; their line is forced to zero.
    assign push_data = s1_err ? '0 : inst_mem_rd_data;
    assign push      = s1_vld;
    assign pop       = fetch_mem_ack_vld && fetch_mem_ack_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_err <= '0;
        end else begin
            if (push) begin
                wr_ptr           <= ptr_inc(wr_ptr);
                fifo_err[wr_ptr] <= s1_err;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed behind a nonzero count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_id[wr_ptr]   <= s1_id;
        end
    end

    assign fetch_mem_ack_vld      = (count != '0);
    assign fetch_mem_ack_data     = fifo_data[rd_ptr];
    assign fetch_mem_ack_entry_id = fifo_id[rd_ptr];

`ifdef FETCH_RSP_ADDR_CHK_EN
    assign fetch_mem_ack_err = fetch_mem_ack_vld && fifo_err[rd_ptr];
`else
    logic unused_err;
    assign unused_err = ^fifo_err;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == CNT_W'(RSP_FIFO_DEPTH))));

endmodule

// File: tb/tb_toy_fetch_mem_rsp.sv
// tb/tb_toy_fetch_mem_rsp.sv - directed self-checking bench for toy_fetch_mem_rsp
module tb_toy_fetch_mem_rsp;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_vld;
    logic         req_rdy;
    logic [31:0]  req_addr;
    logic [3:0]   req_id;
    logic         ack_vld;
    logic         ack_rdy;
    logic [127:0] ack_data;
    logic [3:0]   ack_id;
`ifdef FETCH_RSP_ADDR_CHK_EN
    logic         ack_err;
`endif
    logic         inst_mem_en;
    logic [31:0]  inst_mem_addr;
    logic [127:0] inst_mem_rd_data;

    always #5 clk = ~clk;

    toy_fetch_mem_rsp dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .fetch_mem_req_vld      (req_vld),
        .fetch_mem_req_rdy      (req_rdy),
        .fetch_mem_req_addr     (req_addr),
        .fetch_mem_req_entry_id (req_id),
        .fetch_mem_ack_vld      (ack_vld),
        .fetch_mem_ack_rdy      (ack_rdy),
        .fetch_mem_ack_data     (ack_data),
        .fetch_mem_ack_entry_id (ack_id),
`ifdef FETCH_RSP_ADDR_CHK_EN
        .fetch_mem_ack_err      (ack_err),
`endif
        .inst_mem_en            (inst_mem_en),
        .inst_mem_addr          (inst_mem_addr),
        .inst_mem_rd_data       (inst_mem_rd_data)
    );

    function automatic logic [127:0] memfn(input logic [31:0] a);
        return {a ^ 32'h1111_0000, ~a, a + 32'h0BAD_0000, a[15:0], 16'hC0DE};
    endfunction

    function automatic logic in_win(input logic [31:0] a);
`ifdef FETCH_RSP_ADDR_CHK_EN
        return a < 32'h0001_0000;
`else
        return (^a) | 1'b1;
`endif
    endfunction

    // SRAM model: single-cycle read latency
    always_ff @(posedge clk) begin
        if (inst_mem_en) inst_mem_rd_data <= memfn(inst_mem_addr);
    end

    typedef struct {
        logic [3:0]   id;
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t        q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_acc  = 0;
    int          n_acks = 0;
    int          n_err_seen = 0;
    logic [31:0] cur_addr;
    logic [3:0]  cur_id;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, observe #1 later, update the scoreboard.
    task automatic step(input logic vld, input logic ardy);
        logic        acc;
        logic        win;
        logic [31:0] al;
        exp_t        e;
        @(negedge clk);
        req_vld  = vld;
        req_addr = cur_addr;
        req_id   = cur_id;
        ack_rdy  = ardy;
        #1;
        acc = vld && req_rdy;
        win = in_win(cur_addr);
        al  = cur_addr & ~32'hF;
        check_val("mem_en", 128'(inst_mem_en), 128'(acc && win));
        if (acc && win) check_val("mem_addr", 128'(inst_mem_addr), 128'(al));
        if (ack_vld) begin
            if (q.size() == 0) begin
                check_val("ack_spurious", 128'(ack_vld), 128'(1'b0));
            end else begin
                check_val("ack_id", 128'(ack_id), 128'(q[0].id));
                check_val("ack_data", ack_data, q[0].data);
`ifdef FETCH_RSP_ADDR_CHK_EN
                check_val("ack_err", 128'(ack_err), 128'(q[0].err));
                if (ardy && ack_err) n_err_seen++;
`endif
                if (ardy) begin
                    void'(q.pop_front());
                    n_acks++;
                end
            end
        end
        if (acc) begin
            e.id   = cur_id;
            e.data = win ? memfn(al) : '0;
            e.err  = !win;
            q.push_back(e);
            n_acc++;
            cur_id   = cur_id + 4'd1;
            cur_addr = cur_addr + 32'h14;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        req_vld  = 1'b0;
        req_addr = '0;
        req_id   = '0;
        ack_rdy  = 1'b0;
        cur_addr = '0;
        cur_id   = '0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_ack_vld", 128'(ack_vld), 128'(1'b0));
        check_val("rst_req_rdy", 128'(req_rdy), 128'(1'b1));
        check_val("rst_mem_en", 128'(inst_mem_en), 128'(1'b0));
`ifdef FETCH_RSP_ADDR_CHK_EN
        check_val("rst_ack_err", 128'(ack_err), 128'(1'b0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single request, unaligned address
        cur_addr = 32'h104;
        cur_id   = 4'd3;
        step(1'b1, 1'b1);
        check_val("t1_rdy", 128'(req_rdy), 128'(1'b1));
        check_val("t1_en", 128'(inst_mem_en), 128'(1'b1));
        check_val("t1_addr", 128'(inst_mem_addr), 128'(32'h100));
        step(1'b0, 1'b1);
        check_val("t1_ack_early", 128'(ack_vld), 128'(1'b0));
        step(1'b0, 1'b1);
        check_val("t1_ack_vld", 128'(ack_vld), 128'(1'b1));
        check_val("t1_ack_id", 128'(ack_id), 128'(4'd3));
        check_val("t1_ack_data", ack_data, memfn(32'h100));
        step(1'b0, 1'b1);
        check_val("t1_ack_done", 128'(ack_vld), 128'(1'b0));

        // 2: eight back-to-back requests, acks on consecutive cycles from T+2
        cur_addr = 32'h1000;
        cur_id   = 4'd0;
        for (int k = 0; k < 12; k++) begin
            step(k < 8, 1'b1);
            if (k < 8) check_val("t2_rdy", 128'(req_rdy), 128'(1'b1));
            if (k >= 2 && k < 10) begin
                check_val("t2_ack_vld", 128'(ack_vld), 128'(1'b1));
                check_val("t2_ack_seq", 128'(ack_id), 128'(k - 2));
            end
            if (k >= 10) check_val("t2_ack_idle", 128'(ack_vld), 128'(1'b0));
        end

        // 3: ack_rdy low, continuous requests -> exactly DEPTH accepted, head held
        cur_addr = 32'h2000;
        cur_id   = 4'd8;
        n_acc    = 0;
        n_acks   = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0);
            if (k >= 2) begin
                check_val("t3_head_vld", 128'(ack_vld), 128'(1'b1));
                check_val("t3_head_id", 128'(ack_id), 128'(4'd8));
                check_val("t3_head_data", ack_data, memfn(32'h2000));
            end
            if (k >= 5) check_val("t3_rdy_low", 128'(req_rdy), 128'(1'b0));
        end
        check_val("t3_accepts", 128'(n_acc), 128'(4));

        // 4: full FIFO, both sides active -> one pop per cycle, slots reopen
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1);
            if (k == 0) check_val("t4_rdy_full", 128'(req_rdy), 128'(1'b0));
            if (k == 1) check_val("t4_rdy_back", 128'(req_rdy), 128'(1'b1));
            check_val("t4_occupancy", 128'(q.size() <= 4), 128'(1'b1));
        end
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1);
        check_val("t4_drained", 128'(q.size()), 128'(0));
        check_val("t4_ack_idle", 128'(ack_vld), 128'(1'b0));
        check_val("t4_no_loss", 128'(n_acks), 128'(n_acc));

        // 5: reset with two requests in flight
        cur_addr = 32'h3000;
        cur_id   = 4'd5;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        @(negedge clk);
        req_vld = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_val("t5_rst_ack_vld", 128'(ack_vld), 128'(1'b0));
        check_val("t5_rst_rdy", 128'(req_rdy), 128'(1'b1));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("t5_ack_vld", 128'(ack_vld), 128'(1'b0));
        check_val("t5_req_rdy", 128'(req_rdy), 128'(1'b1));
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1);
            check_val("t5_no_stale", 128'(ack_vld), 128'(1'b0));
        end
        cur_addr = 32'h3400;
        cur_id   = 4'd12;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_val("t5_new_id", 128'(ack_id), 128'(4'd12));
        step(1'b0, 1'b1);
        check_val("t5_empty", 128'(q.size()), 128'(0));

`ifdef FETCH_RSP_ADDR_CHK_EN
        // 6: out-of-window request between two legal ones
        n_err_seen = 0;
        cur_addr = 32'h200;
        cur_id   = 4'd1;
        step(1'b1, 1'b1);
        cur_addr = 32'h20000;
        step(1'b1, 1'b1);
        check_val("t6_en_off", 128'(inst_mem_en), 128'(1'b0));
        cur_addr = 32'h300;
        step(1'b1, 1'b1);
        check_val("t6_en_on", 128'(inst_mem_en), 128'(1'b1));
        check_val("t6_ack_id0", 128'(ack_id), 128'(4'd1));
        step(1'b0, 1'b1);
        check_val("t6_err_id", 128'(ack_id), 128'(4'd2));
        check_val("t6_err_flag", 128'(ack_err), 128'(1'b1));
        check_val("t6_err_data", ack_data, 128'(0));
        step(1'b0, 1'b1);
        check_val("t6_ack_id2", 128'(ack_id), 128'(4'd3));
        check_val("t6_ok_flag", 128'(ack_err), 128'(1'b0));
        step(1'b0, 1'b1);
        check_val("t6_err_count", 128'(n_err_seen), 128'(1));
        check_val("t6_empty", 128'(q.size()), 128'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
